// File: rtl/fetch_decode_unit.sv
// Fetch/decode stage: PC register, combinational-read instruction memory and
// main control decode for the single-cycle MIPS datapath.
module fetch_decode_unit #(
  parameter int IMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_next,
  input  logic        imem_we,
  input  logic [31:0] imem_waddr,
  input  logic [31:0] imem_wdata,
  output logic [31:0] pc,
  output logic [31:0] instruction,
  output logic        RegDst,
  output logic        Branch,
  output logic        MemtoReg,
  output logic        MemWrite,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic        Jump,
  output logic [6:0]  ALUOp,
  output logic [1:0]  MemRead
);

  localparam int AW = $clog2(IMEM_WORDS);

  localparam logic [6:0] ALU_ADD   = 7'd0;
  localparam logic [6:0] ALU_SUB   = 7'd1;
  localparam logic [6:0] ALU_FUNCT = 7'd2;
  localparam logic [6:0] ALU_AND   = 7'd3;
  localparam logic [6:0] ALU_OR    = 7'd4;
  localparam logic [6:0] ALU_SLT   = 7'd5;
  localparam logic [6:0] ALU_LUI   = 7'd6;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  logic [31:0] pc_d, pc_q;
  logic [31:0] mem_q [IMEM_WORDS];

  logic [AW-1:0] rd_idx, wr_idx;
  logic          rd_in_range, wr_in_range;
  logic          unused_waddr_lo;
  logic [5:0]    opcode;

  always_comb begin
    pc_d = pc_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= '0;
    else     pc_q <= pc_d;
  end

  assign pc = pc_q;

  // Anything above the top word reads as 0 (nop) instead of aliasing low words.
  assign rd_idx      = pc_q[AW+1:2];
  assign rd_in_range = ((pc_q >> (AW + 2)) == 32'd0);
  assign wr_idx      = imem_waddr[AW+1:2];
  assign wr_in_range = ((imem_waddr >> (AW + 2)) == 32'd0);
  assign unused_waddr_lo = ^imem_waddr[1:0];

  // Memory is loaded independently of rst so a program can be staged in reset.
  always_ff @(posedge clk) begin
    if (imem_we && wr_in_range) mem_q[wr_idx] <= imem_wdata;
  end

  assign instruction = rd_in_range ? mem_q[rd_idx] : 32'd0;
  assign opcode      = instruction[31:26];

  always_comb begin
    RegDst   = 1'b0;
    Branch   = 1'b0;
    MemtoReg = 1'b0;
    MemWrite = 1'b0;
    ALUSrc   = 1'b0;
    RegWrite = 1'b0;
    Jump     = 1'b0;
    ALUOp    = ALU_ADD;
    MemRead  = 2'b00;
    unique case (opcode)
      OP_RTYPE: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        ALUOp    = ALU_FUNCT;
      end
      OP_LW, OP_LH, OP_LB: begin
        ALUSrc   = 1'b1;
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        ALUOp    = ALU_ADD;
        MemRead  = (opcode == OP_LW) ? 2'b11 :
                   (opcode == OP_LH) ? 2'b10 : 2'b01;
      end
      OP_SW: begin
        ALUSrc   = 1'b1;
        MemWrite = 1'b1;
        ALUOp    = ALU_ADD;
      end
      OP_BEQ: begin
        Branch = 1'b1;
        ALUOp  = ALU_SUB;
      end
      OP_J: Jump = 1'b1;
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI: begin
        ALUSrc   = 1'b1;
        RegWrite = 1'b1;
        ALUOp    = (opcode == OP_ANDI) ? ALU_AND :
                   (opcode == OP_ORI)  ? ALU_OR  :
                   (opcode == OP_SLTI) ? ALU_SLT :
                   (opcode == OP_LUI)  ? ALU_LUI : ALU_ADD;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Directed bench for fetch_decode_unit with a scoreboard of expected fetch/decode results.
module tb_fetch_decode_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_next;
  logic        imem_we;
  logic [31:0] imem_waddr, imem_wdata;
  logic [31:0] pc, instruction;
  logic        RegDst, Branch, MemtoReg, MemWrite, ALUSrc, RegWrite, Jump;
  logic [6:0]  ALUOp;
  logic [1:0]  MemRead;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [15:0] ctrl;
  } exp_t;

  exp_t sb[$];

  fetch_decode_unit #(.IMEM_WORDS(64)) dut (
    .clk(clk), .rst(rst), .pc_next(pc_next),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .pc(pc), .instruction(instruction),
    .RegDst(RegDst), .Branch(Branch), .MemtoReg(MemtoReg), .MemWrite(MemWrite),
    .ALUSrc(ALUSrc), .RegWrite(RegWrite), .Jump(Jump),
    .ALUOp(ALUOp), .MemRead(MemRead)
  );

  always #5 clk = ~clk;

  // Packing: {RegDst,Branch,MemtoReg,MemWrite,ALUSrc,RegWrite,Jump,ALUOp[6:0],MemRead[1:0]}
  function automatic logic [15:0] mk(input logic rd, br, m2r, mw, as, rw, j,
                                     input logic [6:0] op, input logic [1:0] mr);
    return {rd, br, m2r, mw, as, rw, j, op, mr};
  endfunction

  localparam logic [31:0] W_LW   = 32'h8C220004;
  localparam logic [31:0] W_ADD  = 32'h00430820;
  localparam logic [31:0] W_SW   = 32'hAC220008;
  localparam logic [31:0] W_BEQ  = 32'h10220003;
  localparam logic [31:0] W_J    = 32'h08000010;
  localparam logic [31:0] W_ADDI = 32'h20010005;
  localparam logic [31:0] W_ANDI = 32'h30010005;
  localparam logic [31:0] W_ORI  = 32'h34010005;
  localparam logic [31:0] W_SLTI = 32'h28010005;
  localparam logic [31:0] W_LUI  = 32'h3C010005;
  localparam logic [31:0] W_LB   = 32'h80220000;
  localparam logic [31:0] W_LH   = 32'h84220000;
  localparam logic [31:0] W_ILL  = 32'hFC000000;
  localparam logic [31:0] W_NEW  = 32'h3C01ABCD;

  logic [15:0] C_R, C_LW, C_LH, C_LB, C_SW, C_BEQ, C_J;
  logic [15:0] C_ADDI, C_ANDI, C_ORI, C_SLTI, C_LUI;
  logic [31:0] prog [13];

  task automatic compare_out(input string tag);
    exp_t e;
    logic [15:0] got_ctrl;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard empty: got nothing, required an entry", tag);
      return;
    end
    e = sb.pop_front();
    got_ctrl = {RegDst, Branch, MemtoReg, MemWrite, ALUSrc, RegWrite, Jump, ALUOp, MemRead};
    checks++;
    assert (pc === e.pc) else begin
      errors++;
      $error("FAIL %s pc: got %h required %h", tag, pc, e.pc);
    end
    checks++;
    assert (instruction === e.instr) else begin
      errors++;
      $error("FAIL %s instruction: got %h required %h", tag, instruction, e.instr);
    end
    checks++;
    assert (got_ctrl === e.ctrl) else begin
      errors++;
      $error("FAIL %s ctrl: got %h required %h", tag, got_ctrl, e.ctrl);
    end
  endtask

  task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
    imem_we    = 1'b1;
    imem_waddr = addr;
    imem_wdata = data;
    @(posedge clk);
    #1;
    imem_we = 1'b0;
  endtask

  // Drive pc_next, record what the next edge should present, then check it.
  task automatic step(input string tag, input logic [31:0] pcn,
                      input logic [31:0] exp_pc, input logic [31:0] ei,
                      input logic [15:0] ec);
    pc_next = pcn;
    sb.push_back('{exp_pc, ei, ec});
    @(posedge clk);
    #1;
    compare_out(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    C_R    = mk(1,0,0,0,0,1,0,7'd2,2'b00);
    C_LW   = mk(0,0,1,0,1,1,0,7'd0,2'b11);
    C_LH   = mk(0,0,1,0,1,1,0,7'd0,2'b10);
    C_LB   = mk(0,0,1,0,1,1,0,7'd0,2'b01);
    C_SW   = mk(0,0,0,1,1,0,0,7'd0,2'b00);
    C_BEQ  = mk(0,1,0,0,0,0,0,7'd1,2'b00);
    C_J    = mk(0,0,0,0,0,0,1,7'd0,2'b00);
    C_ADDI = mk(0,0,0,0,1,1,0,7'd0,2'b00);
    C_ANDI = mk(0,0,0,0,1,1,0,7'd3,2'b00);
    C_ORI  = mk(0,0,0,0,1,1,0,7'd4,2'b00);
    C_SLTI = mk(0,0,0,0,1,1,0,7'd5,2'b00);
    C_LUI  = mk(0,0,0,0,1,1,0,7'd6,2'b00);
    prog = '{W_LW, W_ADD, W_SW, W_BEQ, W_J, W_ADDI, W_ANDI, W_ORI,
             W_SLTI, W_LUI, W_LB, W_LH, W_ILL};

    rst = 1'b1; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0; pc_next = '0;
    #2;
    // All loads happen while rst is held, so later fetches prove they were kept.
    for (int i = 0; i < 64; i++) write_word(32'(i * 4), 32'd0);
    for (int i = 0; i < 13; i++) write_word(32'(i * 4), prog[i]);

    sb.push_back('{32'd0, W_LW, C_LW});
    compare_out("reset_lw");

    rst = 1'b0;
    step("add", 32'd4,  32'd4,  W_ADD, C_R);
    step("sw",  32'd8,  32'd8,  W_SW,  C_SW);
    step("beq", 32'd12, 32'd12, W_BEQ, C_BEQ);
    step("j",   32'd16, 32'd16, W_J,   C_J);

    // Asynchronous reset in the middle of a cycle.
    #2;
    rst = 1'b1;
    #1;
    sb.push_back('{32'd0, W_LW, C_LW});
    compare_out("async_rst");
    step("rst_hold", 32'h20, 32'd0, W_LW, C_LW);
    rst = 1'b0;

    step("j_again",   32'h10, 32'h10, W_J,    C_J);
    step("jump_tgt",  32'h40, 32'h40, 32'd0,  C_R);
    step("addi",      32'h14, 32'h14, W_ADDI, C_ADDI);
    step("pc_lsb",    32'h17, 32'h17, W_ADDI, C_ADDI);
    step("andi",      32'h18, 32'h18, W_ANDI, C_ANDI);
    step("ori",       32'h1C, 32'h1C, W_ORI,  C_ORI);
    step("slti",      32'h20, 32'h20, W_SLTI, C_SLTI);
    step("lui",       32'h24, 32'h24, W_LUI,  C_LUI);
    step("lb",        32'h28, 32'h28, W_LB,   C_LB);
    step("lh",        32'h2C, 32'h2C, W_LH,   C_LH);
    step("illegal",   32'h30, 32'h30, W_ILL,  16'd0);
    step("oor_0x100", 32'h100, 32'h100, 32'd0, C_R);
    step("oor_top",   32'hFFFFFFFC, 32'hFFFFFFFC, 32'd0, C_R);
    step("pc_wrap",   32'hFFFFFFFC + 32'd4, 32'd0, W_LW, C_LW);

    // Out-of-range write must not alias onto word 0.
    imem_we = 1'b1; imem_waddr = 32'h100; imem_wdata = 32'hFFFFFFFF;
    step("oor_write", 32'd0, 32'd0, W_LW, C_LW);
    imem_we = 1'b0;

    // Same-word write while fetching it.
    step("rw_pc8", 32'd8, 32'd8, W_SW, C_SW);
    imem_we = 1'b1; imem_waddr = 32'd8; imem_wdata = W_NEW;
    #1;
    sb.push_back('{32'd8, W_SW, C_SW});
    compare_out("rw_before");
    step("rw_after", 32'd8, 32'd8, W_NEW, C_LUI);
    imem_we = 1'b0;
    step("ld_kept", 32'd4, 32'd4, W_ADD, C_R);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_decode_unit.md
# fetch_decode_unit

Instruction-fetch and main-decode stage of the single-cycle MIPS datapath. Holds the program counter register, a 64-word instruction memory read combinationally at the PC, and the main control unit that decodes the opcode into datapath control signals. Next-PC arithmetic (PC+4, jump, branch muxing) lives outside this block and returns through `pc_next`.

## Interface
Parameters:
- `IMEM_WORDS`, 64: instruction memory depth in 32-bit words (power of two).

Ports:
- `clk`  in  1  single clock, rising-edge active.
- `rst`  in  1  asynchronous, active-high reset.
- `pc_next`  in  32  PC value loaded at the next rising edge.
- `imem_we`  in  1  instruction-memory load enable.
- `imem_waddr`  in  32  byte address of the word to load.
- `imem_wdata`  in  32  word to load.
- `pc`  out  32  current PC, byte address.
- `instruction`  out  32  word fetched at `pc`.
- `RegDst`, `Branch`, `MemtoReg`, `MemWrite`, `ALUSrc`, `RegWrite`, `Jump`  out  1 each  control signals.
- `ALUOp`  out  7  ALU operation class.
- `MemRead`  out  2  data-memory read size: 00 none, 01 byte, 10 halfword, 11 word.

## Operation
- PC register: `pc <= pc_next` on every rising `clk`. No enable and no stall.
- Imem read is combinational. Word index = `pc[log2(IMEM_WORDS)+1:2]`. `pc[1:0]` is ignored.
- Any `pc` above `4*IMEM_WORDS-1` returns `instruction = 0`, which is a nop.
- Imem write is synchronous on rising `clk` when `imem_we=1`. It uses the same index rule as reads. Out-of-range writes are dropped.
- Imem contents are zero after configuration. Reset does not clear the memory.
- Control decodes from `instruction[31:26]` and is purely combinational. Every output not listed for an opcode is 0.
- ALUOp codes: 0000000 add, 0000001 sub, 0000010 use funct, 0000011 and, 0000100 or, 0000101 slt, 0000110 lui.
- Decode by opcode:
  - 000000 R-type: RegDst=1, RegWrite=1, ALUOp=0000010.
  - 100011 lw: ALUSrc, MemtoReg, RegWrite = 1; MemRead=11; ALUOp=add.
  - 100001 lh: same as lw but MemRead=10.
  - 100000 lb: same as lw but MemRead=01.
  - 101011 sw: ALUSrc=1, MemWrite=1; ALUOp=add.
  - 000100 beq: Branch=1; ALUOp=sub.
  - 000010 j: Jump=1.
  - 001000 addi: ALUSrc, RegWrite = 1; ALUOp=add.
  - 001100 andi: ALUSrc, RegWrite = 1; ALUOp=and.
  - 001101 ori: ALUSrc, RegWrite = 1; ALUOp=or.
  - 001010 slti: ALUSrc, RegWrite = 1; ALUOp=slt.
  - 001111 lui: ALUSrc, RegWrite = 1; ALUOp=lui.
  - All other opcodes: every output 0, so no state change downstream.
- Opcode 000000 with an all-zero word (nop) still decodes as R-type. Writing $0 is harmless downstream.

## Timing
- Reset takes effect immediately, independent of `clk`: `pc=0`. `instruction` and the controls then reflect `mem[0]`.
- While `rst=1`, `pc` holds 0. On the first rising edge after `rst` falls, `pc` loads `pc_next`.
- `instruction` and the control outputs settle combinationally in the same cycle as `pc`. Latency from a PC update to valid controls is zero cycles.
- Write and read of the same word in one cycle: the read returns the old word until the edge and the new word after it.
- `imem_we` is honoured during reset; reset does not block loads.
- `pc` wraps naturally modulo 2^32 when driven by `pc_next`. No internal saturation.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle with `pc=0x10` → `pc=0` without waiting for a clock; `instruction=mem[0]`.
- Sequential fetch: load words 0x8C220004 (lw), 0x00430820 (add), 0xAC220008 (sw), 0x10220003 (beq) at 0..12. Drive `pc_next=pc+4` → each cycle decodes as follows:
  - lw: ALUSrc, MemtoReg, RegWrite; MemRead=11.
  - add: RegDst, RegWrite; ALUOp=0000010.
  - sw: ALUSrc, MemWrite.
  - beq: Branch; ALUOp=0000001.
- Jump: instruction 0x08000010 → Jump=1, all other controls 0. Driving `pc_next=0x40` → `pc=0x40` after one edge.
- Immediates: addi, andi, ori, slti and lui opcodes → ALUSrc=1, RegWrite=1, ALUOp=0,3,4,5,6 respectively. lb and lh give MemRead=01 and 10.
- Illegal opcode 111111 → all controls 0. `pc=0x100` with `IMEM_WORDS=64` → `instruction=0`.
- Same-word write/read at `pc=8` → old word before the edge, new word after it. A load during `rst=1` is retained.
